act_requant: RTL and testbench



---
 rtl/act_requant_pkg.sv | 23 ++
 rtl/act_requant_unit.sv | 43 ++++
 rtl/act_requant.sv | 116 +++++++++++
 tb/tb_act_requant.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_requant_pkg.sv
// Shared definitions for the activation/requantization stage.
package act_requant_pkg;

    // FSM state codes, 4 bits wide to match the conv2d controller encoding.
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RUN   = 4'd1,
        S_DRAIN = 4'd2,
        S_DONE  = 4'd3
    } state_t;

    // Activation mode codes; any other value behaves as identity.
    localparam int ACT_IDENTITY = 0;
    localparam int ACT_RELU     = 1;
    localparam int ACT_LEAKY    = 2;

    // Number of elements streamed through for one job.
    function automatic int unsigned elem_count(int unsigned batch, int unsigned chans,
                                               int unsigned rows, int unsigned cols);
        return batch * chans * rows * cols;
    endfunction

endpackage

// File: rtl/act_requant_unit.sv
// Combinational datapath: activation, round-half-up right shift, signed saturation.
module act_requant_unit
    import act_requant_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACT_MODE   = 2,
    parameter int NEG_SHIFT  = 3,
    parameter int OUT_SHIFT  = 0,
    parameter int OUT_WIDTH  = 8
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic signed [DATA_WIDTH-1:0] y
);

    // One guard bit so the rounding add can never overflow.
    localparam int W = DATA_WIDTH + 1;

    localparam logic signed [W-1:0] RND =
        (OUT_SHIFT > 0) ? (W'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
    localparam logic signed [W-1:0] MAXV = {{(W + 1 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {{(W + 1 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [W-1:0] xe;
    logic signed [W-1:0] a;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] r;

    // Activate, round, then clamp into the OUT_WIDTH signed range.
    always_comb begin
        xe = $signed({x[DATA_WIDTH-1], x});
        a  = xe;
        if (x[DATA_WIDTH-1]) begin
            if (ACT_MODE == ACT_RELU)       a = '0;
            else if (ACT_MODE == ACT_LEAKY) a = xe >>> NEG_SHIFT;
        end
        sum = a + RND;
        r   = sum >>> OUT_SHIFT;
        if (r > MAXV)      y = MAXV[DATA_WIDTH-1:0];
        else if (r < MINV) y = MINV[DATA_WIDTH-1:0];
        else               y = r[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/act_requant.sv
// Streams a source buffer through activation + requantization into a destination buffer.
module act_requant
    import act_requant_pkg::*;
#(
    parameter int BATCH_SIZE = 1,
    parameter int CHANNELS   = 1,
    parameter int HEIGHT     = 2,
    parameter int WIDTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int SRC_BASE   = 0,
    parameter int DST_BASE   = 0,
    parameter int ACT_MODE   = 2,
    parameter int NEG_SHIFT  = 3,
    parameter int OUT_SHIFT  = 0,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_en,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic                  dst_we,
    output logic                  dst_en
);

    localparam int unsigned N      = elem_count(BATCH_SIZE, CHANNELS, HEIGHT, WIDTH);
    localparam int          STAGES = 2;

    state_t                 state;
    state_t                 state_nxt;
    logic [31:0]            rd_cnt;
    logic [31:0]            rd_idx;
    // Stage 0 valid is src_en itself; [1] = read data on the bus, [2] = write issued.
    logic [STAGES:1]        vld_pipe;
    logic signed [DATA_WIDTH-1:0] unit_y;

    act_requant_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACT_MODE  (ACT_MODE),
        .NEG_SHIFT (NEG_SHIFT),
        .OUT_SHIFT (OUT_SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_unit (
        .x(src_data),
        .y(unit_y)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state plus read-side and handshake outputs.
    always_comb begin
        state_nxt = state;
        src_en    = 1'b0;
        src_addr  = '0;
        done      = 1'b0;
        valid     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                src_en   = 1'b1;
                src_addr = ADDR_WIDTH'(SRC_BASE + rd_cnt);
                if (rd_cnt == N - 1) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Last read's data is no longer pending once stage 1 empties;
                // its write is on the port this very cycle.
                if (!vld_pipe[1]) state_nxt = S_DONE;
            end
            S_DONE: begin
                done  = 1'b1;
                valid = 1'b1;
                if (!start) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read counter: cleared in IDLE, saturates at the last element.
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE)
            rd_cnt <= '0;
        else if (state == S_RUN && rd_cnt != N - 1)
            rd_cnt <= rd_cnt + 32'd1;
    end

    // Two-stage valid/index pipeline; stage 2 registers the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            rd_idx   <= '0;
            dst_addr <= '0;
            dst_data <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], src_en};
            rd_idx   <= rd_cnt;
            dst_addr <= vld_pipe[1] ? ADDR_WIDTH'(DST_BASE + rd_idx) : '0;
            dst_data <= vld_pipe[1] ? unit_y : '0;
        end
    end

    assign dst_we = vld_pipe[STAGES];
    assign dst_en = vld_pipe[STAGES];

endmodule

// File: tb/tb_act_requant.sv
// Self-checking bench: five differently parameterised instances, directed and random jobs.
module tb_act_requant;

    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start    [NI];
    logic        done     [NI];
    logic        valid    [NI];
    logic        src_en   [NI];
    logic        dst_we   [NI];
    logic        dst_en   [NI];
    logic [15:0] src_addr [NI];
    logic [15:0] dst_addr [NI];
    logic [31:0] src_data [NI];
    logic [31:0] dst_data [NI];

    // Per-instance configuration, mirrored from the instance parameters below.
    int p_mode [NI] = '{2, 1, 2, 2, 3};
    int p_ns   [NI] = '{3, 3, 3, 3, 3};
    int p_os   [NI] = '{0, 2, 2, 0, 5};
    int p_ow   [NI] = '{8, 32, 8, 8, 32};
    int p_n    [NI] = '{4, 4, 4, 24, 1};
    int p_sb   [NI] = '{0, 0, 0, 100, 0};
    int p_db   [NI] = '{0, 0, 0, 500, 0};

    act_requant u0 (
        .clk(clk), .rst(rst), .start(start[0]), .done(done[0]), .valid(valid[0]),
        .src_addr(src_addr[0]), .src_data(src_data[0]), .src_en(src_en[0]),
        .dst_addr(dst_addr[0]), .dst_data(dst_data[0]), .dst_we(dst_we[0]), .dst_en(dst_en[0]));

    act_requant #(.ACT_MODE(1), .OUT_SHIFT(2), .OUT_WIDTH(32)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .done(done[1]), .valid(valid[1]),
        .src_addr(src_addr[1]), .src_data(src_data[1]), .src_en(src_en[1]),
        .dst_addr(dst_addr[1]), .dst_data(dst_data[1]), .dst_we(dst_we[1]), .dst_en(dst_en[1]));

    act_requant #(.ACT_MODE(2), .NEG_SHIFT(3), .OUT_SHIFT(2)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .done(done[2]), .valid(valid[2]),
        .src_addr(src_addr[2]), .src_data(src_data[2]), .src_en(src_en[2]),
        .dst_addr(dst_addr[2]), .dst_data(dst_data[2]), .dst_we(dst_we[2]), .dst_en(dst_en[2]));

    act_requant #(.BATCH_SIZE(2), .CHANNELS(3), .SRC_BASE(100), .DST_BASE(500)) u3 (
        .clk(clk), .rst(rst), .start(start[3]), .done(done[3]), .valid(valid[3]),
        .src_addr(src_addr[3]), .src_data(src_data[3]), .src_en(src_en[3]),
        .dst_addr(dst_addr[3]), .dst_data(dst_data[3]), .dst_we(dst_we[3]), .dst_en(dst_en[3]));

    act_requant #(.HEIGHT(1), .WIDTH(1), .ACT_MODE(3), .OUT_SHIFT(5), .OUT_WIDTH(32)) u4 (
        .clk(clk), .rst(rst), .start(start[4]), .done(done[4]), .valid(valid[4]),
        .src_addr(src_addr[4]), .src_data(src_data[4]), .src_en(src_en[4]),
        .dst_addr(dst_addr[4]), .dst_data(dst_data[4]), .dst_we(dst_we[4]), .dst_en(dst_en[4]));

    // Source memories with one-cycle read latency.
    logic [31:0] src_mem [NI][1024];
    always @(posedge clk)
        for (int k = 0; k < NI; k++)
            if (src_en[k]) src_data[k] <= src_mem[k][src_addr[k][9:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: logs every read and write with its cycle number.
    int     wcnt [NI], rcnt [NI], en_bad [NI], done_cyc [NI];
    logic   done_q [NI];
    int     wcyc  [NI][256], waddr [NI][256], rcyc [NI][256], raddr [NI][256];
    longint wdata [NI][256];
    initial for (int k = 0; k < NI; k++) begin
        wcnt[k] = 0; rcnt[k] = 0; en_bad[k] = 0; done_cyc[k] = -1; done_q[k] = 1'b0;
    end
    always @(negedge clk)
        for (int k = 0; k < NI; k++) begin
            if (dst_we[k]) begin
                wcyc[k][wcnt[k] & 255]  = cyc;
                waddr[k][wcnt[k] & 255] = int'(dst_addr[k]);
                wdata[k][wcnt[k] & 255] = longint'($signed(dst_data[k]));
                wcnt[k]++;
            end
            if (src_en[k]) begin
                rcyc[k][rcnt[k] & 255]  = cyc;
                raddr[k][rcnt[k] & 255] = int'(src_addr[k]);
                rcnt[k]++;
            end
            if (dst_en[k] !== dst_we[k]) en_bad[k]++;
            if (done[k] && !done_q[k]) done_cyc[k] = cyc;
            done_q[k] = done[k];
        end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string tag, longint got, longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample point: just after the falling edge, far from the active edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Floor division for positive divisors.
    function automatic longint fdiv(longint num, longint den);
        longint q;
        q = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    // Reference: activation, round half up, clamp to OUT_WIDTH signed range.
    function automatic longint ref_y(int k, longint x);
        longint a, r, hi, lo, half;
        if (x >= 0 || (p_mode[k] != 1 && p_mode[k] != 2)) a = x;
        else if (p_mode[k] == 1)                            a = 0;
        else                                                a = fdiv(x, longint'(1) << p_ns[k]);
        half = (p_os[k] > 0) ? (longint'(1) << (p_os[k] - 1)) : 0;
        r    = fdiv(a + half, longint'(1) << p_os[k]);
        hi   = (longint'(1) << (p_ow[k] - 1)) - 1;
        lo   = -(longint'(1) << (p_ow[k] - 1));
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    task automatic load4(int k, int v0, int v1, int v2, int v3);
        src_mem[k][p_sb[k] + 0] = v0;
        src_mem[k][p_sb[k] + 1] = v1;
        src_mem[k][p_sb[k] + 2] = v2;
        src_mem[k][p_sb[k] + 3] = v3;
    endtask

    task automatic fill(int k);
        int v;
        for (int j = 0; j < p_n[k]; j++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 600)) - 300;
                1:       v = int'($urandom());
                2:       v = -int'($urandom_range(0, 5000));
                default: v = (j % 2 == 1) ? 32'h7fffffff : 32'h80000000;
            endcase
            src_mem[k][p_sb[k] + j] = v;
        end
    endtask

    // Run one job and check every read, write, the timing and the handshake.
    task automatic run_job(int k, bit hold, string tag, output int wb);
        int rb, n, last;
        n  = p_n[k];
        wb = wcnt[k];
        rb = rcnt[k];
        start[k] = 1'b1;
        step();
        if (!hold) start[k] = 1'b0;
        for (int c = 0; c < n + 10 && !done[k]; c++) step();
        chk({tag, ".done"}, done[k], 1);
        chk({tag, ".valid"}, valid[k], 1);
        chk({tag, ".nwr"}, wcnt[k] - wb, n);
        chk({tag, ".nrd"}, rcnt[k] - rb, n);
        for (int j = 0; j < n; j++) begin
            chk($sformatf("%s.raddr%0d", tag, j), raddr[k][(rb + j) & 255], p_sb[k] + j);
            chk($sformatf("%s.waddr%0d", tag, j), waddr[k][(wb + j) & 255], p_db[k] + j);
            chk($sformatf("%s.data%0d", tag, j), wdata[k][(wb + j) & 255],
                ref_y(k, longint'($signed(src_mem[k][p_sb[k] + j]))));
            chk($sformatf("%s.wcyc%0d", tag, j), wcyc[k][(wb + j) & 255],
                rcyc[k][rb & 255] + 2 + j);
        end
        last = wcyc[k][(wb + n - 1) & 255];
        chk({tag, ".done_cyc"}, done_cyc[k], last + 1);
        chk({tag, ".en_eq_we"}, en_bad[k], 0);
        if (!hold) begin
            step();
            chk({tag, ".done_drop"}, done[k], 0);
        end
    endtask

    task automatic chk_lit(int k, int wb, string tag, int e0, int e1, int e2, int e3);
        chk({tag, ".lit0"}, wdata[k][(wb + 0) & 255], e0);
        chk({tag, ".lit1"}, wdata[k][(wb + 1) & 255], e1);
        chk({tag, ".lit2"}, wdata[k][(wb + 2) & 255], e2);
        chk({tag, ".lit3"}, wdata[k][(wb + 3) & 255], e3);
    endtask

    initial begin
        int wb, rb0, c;
        for (int k = 0; k < NI; k++) start[k] = 1'b0;
        for (int k = 0; k < NI; k++)
            for (int a = 0; a < 1024; a++) src_mem[k][a] = '0;
        rst = 1'b1;
        repeat (3) step();

        // Reset state.
        chk("rst.done",     done[0], 0);
        chk("rst.valid",    valid[0], 0);
        chk("rst.src_en",   src_en[0], 0);
        chk("rst.dst_we",   dst_we[0], 0);
        chk("rst.dst_en",   dst_en[0], 0);
        chk("rst.src_addr", src_addr[0], 0);
        chk("rst.dst_addr", dst_addr[0], 0);
        chk("rst.dst_data", dst_data[0], 0);
        rst = 1'b0;
        step();

        // Directed jobs with literal expectations.
        load4(0, 10, -16, 300, -2000);
        run_job(0, 1'b0, "t1", wb);
        chk_lit(0, wb, "t1", 10, -2, 127, -128);

        load4(1, 6, -6, 5, 1);
        run_job(1, 1'b0, "t2", wb);
        chk_lit(1, wb, "t2", 2, 0, 1, 0);

        load4(2, -6, -1, -64, 7);
        run_job(2, 1'b0, "t3", wb);
        chk_lit(2, wb, "t3", 0, 0, -2, 2);

        // Reset while element 2 is in flight, then a clean job.
        fill(0);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        c = 0;
        while (!(src_en[0] && src_addr[0] == 16'd2) && c < 10) begin
            step();
            c++;
        end
        chk("t4.reach_e2", src_addr[0], 2);
        rst = 1'b1;
        step();
        chk("t4.src_en", src_en[0], 0);
        chk("t4.dst_we", dst_we[0], 0);
        chk("t4.dst_en", dst_en[0], 0);
        chk("t4.done",   done[0], 0);
        chk("t4.valid",  valid[0], 0);
        rst = 1'b0;
        rb0 = rcnt[0];
        repeat (3) step();
        chk("t4.idle_no_rd", rcnt[0] - rb0, 0);
        run_job(0, 1'b0, "t4", wb);

        // start held high through DONE: no restart; drop releases; re-raise reruns.
        load4(0, 55, -77, 1000, -3);
        run_job(0, 1'b1, "t5a", wb);
        rb0 = rcnt[0];
        repeat (5) step();
        chk("t5.hold_done",  done[0], 1);
        chk("t5.hold_valid", valid[0], 1);
        chk("t5.hold_no_rd", rcnt[0] - rb0, 0);
        start[0] = 1'b0;
        step();
        chk("t5.drop_done",  done[0], 0);
        chk("t5.drop_valid", valid[0], 0);
        run_job(0, 1'b0, "t5b", wb);
        chk_lit(0, wb, "t5b", 55, -10, 127, -1);

        // Larger buffer with offset bases.
        for (int r = 0; r < 2; r++) begin
            fill(3);
            run_job(3, 1'b0, $sformatf("t6r%0d", r), wb);
        end

        // Random jobs across the remaining configurations.
        for (int r = 0; r < 3; r++) begin
            fill(0);
            run_job(0, 1'b0, $sformatf("rnd0_%0d", r), wb);
        end
        fill(1);
        run_job(1, 1'b0, "rnd1", wb);
        fill(2);
        run_job(2, 1'b0, "rnd2", wb);
        for (int r = 0; r < 4; r++) begin
            fill(4);
            run_job(4, 1'b0, $sformatf("rnd4_%0d", r), wb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
